// File: rtl/xpar_uart_tx_pkg.sv
// Shared definitions for the parallel-bus UART transmitter: register offsets,
// STAT/CTRL bit positions and serializer state encodings.
package xpar_uart_tx_pkg;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_STAT = 2'd1;
   localparam logic [1:0] REG_DIV  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   localparam int unsigned STAT_FULL  = 0;
   localparam int unsigned STAT_EMPTY = 1;
   localparam int unsigned STAT_BUSY  = 2;
   localparam int unsigned STAT_OVF   = 3;
   localparam int unsigned STAT_CNT   = 8;

   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_FLUSH  = 1;
   localparam int unsigned CTRL_OVFCLR = 2;

   localparam int unsigned DIV_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/xpar_uart_tx_shift.sv
// 8N1 serializer: FSM, baud down-counter and bit counter. Requests a new byte
// via pop_ack when leaving IDLE or at the end of STOP.
module xuart_tx_shift
   import xpar_uart_tx_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       data_byte,
   input  logic [DIV_W-1:0] div,
   output logic             txd,
   output logic             busy,
   output logic             pop_ack
);

   tx_state_t        state, state_n;
   logic [DIV_W-1:0] cnt, cnt_n, reload;
   logic [2:0]       bitc, bitc_n;
   logic [7:0]       sh, sh_n;
   logic             last;

   // DIV of 0 and 1 both mean one clock per bit
   assign reload = (div < DIV_W'(2)) ? '0 : div - DIV_W'(1);
   assign last   = (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         bitc  <= '0;
         sh    <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bitc  <= bitc_n;
         sh    <= sh_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = last ? cnt : cnt - DIV_W'(1);
      bitc_n  = bitc;
      sh_n    = sh;
      pop_ack = 1'b0;
      txd     = 1'b1;
      case (state)
         ST_IDLE: begin
            cnt_n = cnt;
            if (start) begin
               state_n = ST_START;
               cnt_n   = reload;
               sh_n    = data_byte;
               pop_ack = 1'b1;
            end
         end
         ST_START: begin
            txd = 1'b0;
            if (last) begin
               state_n = ST_DATA;
               cnt_n   = reload;
               bitc_n  = '0;
            end
         end
         ST_DATA: begin
            txd = sh[0];
            if (last) begin
               cnt_n = reload;
               sh_n  = sh >> 1;
               if (bitc == 3'd7) state_n = ST_STOP;
               else              bitc_n  = bitc + 3'd1;
            end
         end
         ST_STOP: begin
            if (last) begin
               if (start) begin
                  state_n = ST_START;
                  cnt_n   = reload;
                  sh_n    = data_byte;
                  pop_ack = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: rtl/xpar_uart_tx.sv
// Parallel-bus responder: register decode, 16-deep TX FIFO and status,
// feeding the 8N1 serializer.
module xpar_uart_tx
   import xpar_uart_tx_pkg::*;
#(
   parameter int unsigned PAR_AW  = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned DIV_RST = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PAR_AW-1:0] par_addr,
   input  logic              par_re,
   input  logic              par_we,
   input  logic [DATA_W-1:0] par_out,
   output logic [DATA_W-1:0] par_in,
   output logic              txd,
   output logic              irq
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW:0]   wr_ptr, rd_ptr, count;
   logic [DIV_W-1:0]   div;
   logic               en, ovf;
   logic               full, empty, busy, pop, push, accept, flush, ovf_clr;
   logic               wr_div, wr_ctrl;
   logic [1:0]         reg_sel;
   logic               unused_bits;

   assign reg_sel     = par_addr[1:0];
   assign unused_bits = ^{par_addr[PAR_AW-1:2], par_out[DATA_W-1:16]};

   assign count  = wr_ptr - rd_ptr;
   assign full   = (count == (FIFO_AW+1)'(DEPTH));
   assign empty  = (count == '0);

   assign push    = par_we && (reg_sel == REG_DATA);
   assign wr_div  = par_we && (reg_sel == REG_DIV);
   assign wr_ctrl = par_we && (reg_sel == REG_CTRL);
   assign flush   = wr_ctrl && par_out[CTRL_FLUSH];
   assign ovf_clr = wr_ctrl && par_out[CTRL_OVFCLR];
   // A pop in the same cycle frees the slot being written when full
   assign accept  = push && (!full || pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr[FIFO_AW-1:0]] <= par_out[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div <= DIV_W'(DIV_RST);
         en  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         if (wr_div)  div <= par_out[DIV_W-1:0];
         if (wr_ctrl) en  <= par_out[CTRL_EN];
         if (ovf_clr)              ovf <= 1'b0;
         else if (push && !accept) ovf <= 1'b1;
      end
   end

   xuart_tx_shift u_shift (
      .clk       (clk),
      .rst       (rst),
      .start     (en && !empty),
      .data_byte (mem[rd_ptr[FIFO_AW-1:0]]),
      .div       (div),
      .txd       (txd),
      .busy      (busy),
      .pop_ack   (pop)
   );

   assign irq = en && empty && !busy;

   always_comb begin
      par_in = '0;
      if (par_re) begin
         case (reg_sel)
            REG_STAT: begin
               par_in[STAT_FULL]                = full;
               par_in[STAT_EMPTY]               = empty;
               par_in[STAT_BUSY]                = busy;
               par_in[STAT_OVF]                 = ovf;
               par_in[STAT_CNT +: FIFO_AW+1]    = count;
            end
            REG_DIV:  par_in[DIV_W-1:0] = div;
            REG_CTRL: par_in[CTRL_EN]   = en;
            default:  par_in = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_xpar_uart_tx.sv
// Self-checking bench for xpar_uart_tx: scoreboard of queued bytes against
// cycle-exact expected txd waveforms, plus register/status checks.
module tb_xpar_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  par_addr = '0;
   logic        par_re = 1'b0;
   logic        par_we = 1'b0;
   logic [31:0] par_out = '0;
   logic [31:0] par_in;
   logic        txd, irq;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [7:0] sb[$];
   logic       exp_wave[$];

   always #5 clk = ~clk;

   xpar_uart_tx #(.PAR_AW(4), .DATA_W(32), .FIFO_AW(4), .DIV_RST(868)) dut (
      .clk(clk), .rst(rst), .par_addr(par_addr), .par_re(par_re), .par_we(par_we),
      .par_out(par_out), .par_in(par_in), .txd(txd), .irq(irq)
   );

   function automatic void push_bits(input logic v, input int n);
      for (int i = 0; i < n; i++) exp_wave.push_back(v);
   endfunction

   function automatic void push_frame(input logic [7:0] b, input int d);
      push_bits(1'b0, d);
      for (int k = 0; k < 8; k++) push_bits(b[k], d);
      push_bits(1'b1, d);
   endfunction

   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      par_addr = {2'($urandom), a};
      par_out  = d;
      par_we   = 1'b1;
      @(posedge clk);
      #1;
      par_we   = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      par_addr = {2'($urandom), a};
      par_re   = 1'b1;
      #1;
      d        = par_in;
      par_re   = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] r;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b want=1", txd); end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
      checks++;
      if (par_in !== 32'h0) begin errors++; $display("FAIL reset_par_in got=%h want=0", par_in); end
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL reset_stat got=%h want=00000002", r); end
      read_reg(2'd2, r);
      checks++;
      if (r !== 32'd868) begin errors++; $display("FAIL reset_div got=%0d want=868", r); end
      read_reg(2'd3, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", r); end
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd_after got=%b want=1", txd); end
   endtask

   task automatic test_single_frame;
      logic [31:0] r;
      write_reg(2'd2, 32'd4);
      write_reg(2'd3, 32'h1);
      sb.push_back(8'hA5);
      write_reg(2'd0, 32'h0000_00A5);
      exp_wave.delete();
      push_frame(sb.pop_front(), 4);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== exp_wave[i]) begin
            errors++; $display("FAIL frame_a5 cyc=%0d got=%b want=%b", i, txd, exp_wave[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL frame_a5_irq got=%b want=1", irq); end
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL frame_a5_stat got=%h want=00000002", r); end
   endtask

   task automatic test_overflow;
      logic [31:0] r;
      write_reg(2'd3, 32'h0);
      for (int i = 0; i < 17; i++) write_reg(2'd0, 32'($urandom));
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h1009) begin errors++; $display("FAIL ovf_stat got=%h want=00001009", r); end
      read_reg(2'd0, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL data_read got=%h want=0", r); end
      write_reg(2'd3, 32'h4);
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h1001) begin errors++; $display("FAIL ovfclr_stat got=%h want=00001001", r); end
      read_reg(2'd3, r);
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL ctrl_w1_read got=%h want=0", r); end
      write_reg(2'd3, 32'h2);
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL flush_stat got=%h want=00000002", r); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r;
      logic [7:0]  b;
      write_reg(2'd2, 32'd2);
      exp_wave.delete();
      for (int i = 0; i < 3; i++) begin
         b = (i == 0) ? 8'h81 : (i == 1) ? 8'h00 : 8'($urandom);
         sb.push_back(b);
         write_reg(2'd0, {24'h0, b});
      end
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h0300) begin errors++; $display("FAIL b2b_stat got=%h want=00000300", r); end
      for (int i = 0; i < 3; i++) push_frame(sb.pop_front(), 2);
      write_reg(2'd3, 32'h1);
      @(posedge clk);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== exp_wave[i]) begin
            errors++; $display("FAIL b2b_txd cyc=%0d got=%b want=%b", i, txd, exp_wave[i]);
         end
         checks++;
         if (irq !== 1'b0) begin errors++; $display("FAIL b2b_irq_early cyc=%0d got=%b want=0", i, irq); end
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_end got=%b want=1", irq); end
   endtask

   task automatic test_midframe;
      logic [31:0] r;
      logic [7:0]  x, y;
      x = 8'h6B;
      y = 8'($urandom);
      write_reg(2'd2, 32'd8);
      sb.push_back(x);
      sb.push_back(y);
      write_reg(2'd0, {24'h0, x});
      exp_wave.delete();
      x = sb.pop_front();
      push_bits(1'b0, 8);
      for (int k = 0; k < 4; k++) push_bits(x[k], 8);
      for (int k = 4; k < 8; k++) push_bits(x[k], 2);
      push_bits(1'b1, 22);
      @(posedge clk);
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== exp_wave[i]) begin
            errors++; $display("FAIL mid_txd cyc=%0d got=%b want=%b", i, txd, exp_wave[i]);
         end
         par_we = 1'b0;
         if (i == 0) begin par_addr = 4'd0; par_out = {24'h0, y}; par_we = 1'b1; end
         if (i == 1) begin par_addr = 4'd3; par_out = 32'h0; par_we = 1'b1; end
         if (i == 33) begin par_addr = 4'd2; par_out = 32'd2; par_we = 1'b1; end
      end
      par_we = 1'b0;
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h0100) begin errors++; $display("FAIL mid_held_stat got=%h want=00000100", r); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL mid_held_irq got=%b want=0", irq); end
      exp_wave.delete();
      push_frame(sb.pop_front(), 2);
      write_reg(2'd3, 32'h1);
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== exp_wave[i]) begin
            errors++; $display("FAIL mid_next_txd cyc=%0d got=%b want=%b", i, txd, exp_wave[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL mid_next_irq got=%b want=1", irq); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] r;
      write_reg(2'd2, 32'd4);
      write_reg(2'd0, 32'h00);
      write_reg(2'd0, 32'h55);
      @(posedge clk);
      repeat (5) @(negedge clk);
      checks++;
      if (txd !== 1'b0) begin errors++; $display("FAIL rstmid_pre_txd got=%b want=0", txd); end
      rst = 1'b0;
      #1;
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_async_txd got=%b want=1", txd); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      read_reg(2'd1, r);
      checks++;
      if (r !== 32'h2) begin errors++; $display("FAIL rstmid_stat got=%h want=00000002", r); end
      read_reg(2'd2, r);
      checks++;
      if (r !== 32'd868) begin errors++; $display("FAIL rstmid_div got=%0d want=868", r); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_idle_txd cyc=%0d got=%b want=1", i, txd); end
      end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_overflow;
      test_back_to_back;
      test_midframe;
      test_reset_midframe;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
